// File: rtl/accu_half_pkg.sv
// Shared types, binary16 field constants and the saturating adder for the
// multi-channel half-precision accumulator.
package accu_half_pkg;

    localparam int unsigned FP16_W         = 16;
    localparam int unsigned FP16_MANT      = 10;
    localparam int unsigned FP16_EXP       = 5;
    localparam int unsigned FIXEDSIZE_DEF  = 20;
    localparam int unsigned RADIXPOINT_DEF = 11;
    localparam int unsigned SAT_W          = 32;

    typedef struct packed {
        logic                 sign;
        logic [FP16_EXP-1:0]  exp;
        logic [FP16_MANT-1:0] mant;
    } fp16_t;

    typedef struct packed {
        logic signed [SAT_W-1:0] sum;
        logic                    clamp;
    } sat_t;

    // Sign-extended operands in, sum clamped to a w-bit two's complement range out.
    function automatic sat_t sat_add(input logic signed [SAT_W-1:0] a,
                                     input logic signed [SAT_W-1:0] b,
                                     input int unsigned             w);
        logic signed [SAT_W:0] s;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        sat_t                  res;
        s         = (SAT_W+1)'(a) + (SAT_W+1)'(b);
        hi        = ((SAT_W+1)'(1) <<< (w - 1)) - (SAT_W+1)'(1);
        lo        = ~hi;
        res.sum   = SAT_W'(s);
        res.clamp = 1'b0;
        if (s > hi) begin
            res.sum   = SAT_W'(hi);
            res.clamp = 1'b1;
        end else if (s < lo) begin
            res.sum   = SAT_W'(lo);
            res.clamp = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/accu_half_mc_if.sv
// Sample-in / result-out bundle between the MAC lanes and write-back.
interface accu_half_mc_if #(
    parameter int unsigned CH_W = 2
);
    import accu_half_pkg::*;

    logic            in_valid;
    logic            in_first;
    logic [CH_W-1:0] in_ch;
    fp16_t           x;
    logic            clear_all;
    logic            out_valid;
    logic [CH_W-1:0] out_ch;
    fp16_t           r;
    logic            out_ovf;

    modport master (output in_valid, in_first, in_ch, x, clear_all,
                    input  out_valid, out_ch, r, out_ovf);
    modport slave  (input  in_valid, in_first, in_ch, x, clear_all,
                    output out_valid, out_ch, r, out_ovf);
endinterface

// File: rtl/Fixed2Float.sv
// Combinational signed fixed-point -> float conversion; truncates the
// mantissa, flushes underflow to zero and clamps to the largest finite value.
module Fixed2Float #(
    parameter int unsigned FIXEDSIZE  = 20,
    parameter int unsigned FLOATSIZE  = 16,
    parameter int unsigned MANT       = 10,
    parameter int unsigned EXP        = 5,
    parameter int unsigned RADIXPOINT = 11
) (
    input  logic signed [FIXEDSIZE-1:0] fixed,
    output logic [FLOATSIZE-1:0]        float_c
);
    localparam int BIAS = (1 << (EXP - 1)) - 1;
    localparam int EMAX = (1 << EXP) - 2;

    logic                 sgn;
    logic [FIXEDSIZE-1:0] mag;
    logic [MANT-1:0]      man;
    int                   lead;
    int                   e;

    always_comb begin
        sgn  = fixed[FIXEDSIZE-1];
        mag  = sgn ? FIXEDSIZE'(~fixed + FIXEDSIZE'(1)) : FIXEDSIZE'(fixed);
        lead = 0;
        for (int i = 0; i < int'(FIXEDSIZE); i++) begin
            if (mag[i]) lead = i;
        end
        e = lead - int'(RADIXPOINT) + BIAS;
        if (lead >= int'(MANT)) man = MANT'(mag >> (lead - int'(MANT)));
        else                    man = MANT'(mag << (int'(MANT) - lead));
        if (mag == '0 || e <= 0)  float_c = {sgn, (FLOATSIZE-1)'(0)};
        else if (e > EMAX)        float_c = {sgn, EXP'(EMAX), {MANT{1'b1}}};
        else                      float_c = {sgn, EXP'(e), man};
    end
endmodule

// File: rtl/Float2Fixed.sv
// Combinational float -> signed fixed-point conversion; truncates toward zero
// and saturates (with ovf_c) on overflow, infinity and NaN.
module Float2Fixed #(
    parameter int unsigned FIXEDSIZE  = 20,
    parameter int unsigned FLOATSIZE  = 16,
    parameter int unsigned MANT       = 10,
    parameter int unsigned EXP        = 5,
    parameter int unsigned RADIXPOINT = 11
) (
    input  logic [FLOATSIZE-1:0]        f,
    output logic signed [FIXEDSIZE-1:0] fixed_c,
    output logic                        ovf_c
);
    localparam int unsigned MAG_W = FIXEDSIZE + MANT + 1;
    localparam int          BIAS  = (1 << (EXP - 1)) - 1;

    logic             sgn;
    logic [EXP-1:0]   e;
    logic [MANT-1:0]  frac;
    logic [MAG_W-1:0] mag;
    logic [MAG_W-1:0] lim;
    int               sh;

    assign {sgn, e, frac} = f;
    assign lim = MAG_W'(1) << (FIXEDSIZE - 1);

    always_comb begin
        sh    = ((e == '0) ? 1 : int'(e)) - BIAS - int'(MANT) + int'(RADIXPOINT);
        mag   = MAG_W'({(e != '0), frac});
        ovf_c = 1'b0;
        if (e == '1) begin
            mag = '1;
        end else if (sh >= int'(FIXEDSIZE)) begin
            if (mag != '0) mag = '1;
        end else if (sh >= 0) begin
            mag = mag << sh;
        end else if (-sh < int'(MAG_W)) begin
            mag = mag >> (-sh);
        end else begin
            mag = '0;
        end
        // Negative range reaches one step further than positive.
        if (!sgn && mag >= lim) begin
            ovf_c   = 1'b1;
            fixed_c = FIXEDSIZE'(lim - MAG_W'(1));
        end else if (sgn && mag > lim) begin
            ovf_c   = 1'b1;
            fixed_c = FIXEDSIZE'(~lim + MAG_W'(1));
        end else begin
            fixed_c = sgn ? FIXEDSIZE'(~mag + MAG_W'(1)) : FIXEDSIZE'(mag);
        end
    end
endmodule

// File: rtl/accu_half_lane.sv
// One channel: saturating accumulator plus sticky overflow flag.
module accu_half_lane
    import accu_half_pkg::*;
#(
    parameter int unsigned FIXEDSIZE = FIXEDSIZE_DEF
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        clear,
    input  logic                        we,
    input  logic                        first,
    input  logic signed [FIXEDSIZE-1:0] value,
    input  logic                        cvt_ovf,
    output logic signed [FIXEDSIZE-1:0] acc,
    output logic                        ovf
);
    sat_t sum_c;

    assign sum_c = sat_add(SAT_W'(acc), SAT_W'(value), FIXEDSIZE);

    // Clear has priority over a concurrent update.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (we) begin
            if (first) begin
                acc <= value;
                ovf <= cvt_ovf;
            end else begin
                acc <= FIXEDSIZE'(sum_c.sum);
                ovf <= ovf | sum_c.clamp | cvt_ovf;
            end
        end
    end
endmodule

// File: rtl/accu_half_mc.sv
// Multi-channel binary16 accumulator: convert (S1), accumulate (S2),
// convert back and register the result (S3).
module accu_half_mc
    import accu_half_pkg::*;
#(
    parameter int unsigned FIXEDSIZE  = FIXEDSIZE_DEF,
    parameter int unsigned RADIXPOINT = RADIXPOINT_DEF,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic          clock,
    input  logic          resetn,
    accu_half_mc_if.slave bus
);
    logic signed [FIXEDSIZE-1:0] cvt_val;
    logic                        cvt_ovf;
    logic                        s1_valid;
    logic                        s1_first;
    logic                        s1_ovf;
    logic [CH_W-1:0]             s1_ch;
    logic signed [FIXEDSIZE-1:0] s1_val;
    logic                        t_valid;
    logic [CH_W-1:0]             t_ch;
    logic signed [FIXEDSIZE-1:0] acc [CHANNELS];
    logic [CHANNELS-1:0]         ovf;
    logic signed [FIXEDSIZE-1:0] sel_acc;
    logic                        sel_ovf;
    fp16_t                       res_c;

    Float2Fixed #(.FIXEDSIZE(FIXEDSIZE), .FLOATSIZE(FP16_W), .MANT(FP16_MANT),
                  .EXP(FP16_EXP), .RADIXPOINT(RADIXPOINT))
        u_f2x (.f(bus.x), .fixed_c(cvt_val), .ovf_c(cvt_ovf));

    // S1: out-of-range channel tags are dropped here.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_ovf   <= 1'b0;
            s1_ch    <= '0;
            s1_val   <= '0;
        end else begin
            s1_valid <= bus.in_valid && (32'(bus.in_ch) < CHANNELS);
            s1_first <= bus.in_first;
            s1_ovf   <= cvt_ovf;
            s1_ch    <= bus.in_ch;
            s1_val   <= cvt_val;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        accu_half_lane #(.FIXEDSIZE(FIXEDSIZE)) u_lane (
            .clock   (clock),
            .resetn  (resetn),
            .clear   (bus.clear_all),
            .we      (s1_valid && (s1_ch == CH_W'(i))),
            .first   (s1_first),
            .value   (s1_val),
            .cvt_ovf (s1_ovf),
            .acc     (acc[i]),
            .ovf     (ovf[i])
        );
    end

    // S2 tag; a clear on the same edge discards the entry.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            t_valid <= 1'b0;
            t_ch    <= '0;
        end else begin
            t_valid <= s1_valid && !bus.clear_all;
            t_ch    <= s1_ch;
        end
    end

    always_comb begin
        sel_acc = '0;
        sel_ovf = 1'b0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (t_ch == CH_W'(i)) begin
                sel_acc = acc[i];
                sel_ovf = ovf[i];
            end
        end
    end

    Fixed2Float #(.FIXEDSIZE(FIXEDSIZE), .FLOATSIZE(FP16_W), .MANT(FP16_MANT),
                  .EXP(FP16_EXP), .RADIXPOINT(RADIXPOINT))
        u_x2f (.fixed(sel_acc), .float_c(res_c));

    // S3: result fields hold while no result is valid.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bus.out_valid <= 1'b0;
            bus.out_ch    <= '0;
            bus.r         <= '0;
            bus.out_ovf   <= 1'b0;
        end else begin
            bus.out_valid <= t_valid;
            if (t_valid) begin
                bus.out_ch  <= t_ch;
                bus.r       <= res_c;
                bus.out_ovf <= sel_ovf;
            end
        end
    end
endmodule

// File: tb/tb_accu_half_mc.sv
// Scoreboard bench for accu_half_mc: expected results are queued as samples
// are driven and compared whenever out_valid is seen.
module tb_accu_half_mc;
    import accu_half_pkg::*;

    localparam int unsigned CHN = 4;
    localparam int unsigned CHW = 3;

    typedef struct packed {
        logic [CHW-1:0] ch;
        logic [15:0]    r;
        logic           ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    accu_half_mc_if #(.CH_W(CHW)) bus ();

    accu_half_mc #(.FIXEDSIZE(20), .RADIXPOINT(11), .CHANNELS(CHN), .CH_W(CHW)) dut (
        .clock  (clk),
        .resetn (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: out_valid with ch=%0d r=%h ovf=%b, required no output",
                         bus.out_ch, bus.r, bus.out_ovf);
            end else begin
                e = sb.pop_front();
                if ({bus.out_ch, bus.r, bus.out_ovf} !== e) begin
                    errors++;
                    $display("FAIL result: got ch=%0d r=%h ovf=%b, required ch=%0d r=%h ovf=%b",
                             bus.out_ch, bus.r, bus.out_ovf, e.ch, e.r, e.ovf);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void expect_out(input logic [CHW-1:0] ch, input logic [15:0] r, input logic ovf);
        exp_t e;
        e.ch  = ch;
        e.r   = r;
        e.ovf = ovf;
        sb.push_back(e);
    endfunction

    task automatic send(input logic [CHW-1:0] ch, input logic [15:0] xv, input logic first);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_ch     = ch;
        bus.x         = xv;
        bus.in_first  = first;
        bus.clear_all = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.clear_all = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d results still pending, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_ch     = '0;
        bus.x         = '0;
        bus.clear_all = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", bus.out_valid); end
        checks++;
        if (bus.r !== 16'h0000) begin errors++; $display("FAIL reset_r: got %h required 0000", bus.r); end
        checks++;
        if (bus.out_ch !== 3'd0) begin errors++; $display("FAIL reset_ch: got %0d required 0", bus.out_ch); end
        checks++;
        if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b required 0", bus.out_ovf); end
        rst_n = 1'b1;
    endtask

    task automatic test_sequence();
        logic [3:0] ov;
        send(3'd0, 16'h3C00, 1'b1); expect_out(3'd0, 16'h3C00, 1'b0);
        send(3'd0, 16'h4000, 1'b0); expect_out(3'd0, 16'h4200, 1'b0);
        send(3'd0, 16'h3800, 1'b0); expect_out(3'd0, 16'h4300, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: out_valid %b one edge after accept, required 0", bus.out_valid);
        end
        idle();
        ov[0] = bus.out_valid;
        @(negedge clk); ov[1] = bus.out_valid;
        @(negedge clk); ov[2] = bus.out_valid;
        @(negedge clk); ov[3] = bus.out_valid;
        checks++;
        if (ov !== 4'b0111) begin
            errors++;
            $display("FAIL latency_pulse: out_valid pattern %b, required 0111", ov);
        end
        drain("sequence");
    endtask

    task automatic test_interleave();
        logic [15:0] r0 [4];
        logic [15:0] r1 [4];
        r0[0] = 16'h3C00; r0[1] = 16'h4000; r0[2] = 16'h4200; r0[3] = 16'h4400;
        r1[0] = 16'hBC00; r1[1] = 16'hC000; r1[2] = 16'hC200; r1[3] = 16'hC400;
        for (int i = 0; i < 4; i++) begin
            send(3'd0, 16'h3C00, i == 0); expect_out(3'd0, r0[i], 1'b0);
            send(3'd1, 16'hBC00, i == 0); expect_out(3'd1, r1[i], 1'b0);
        end
        idle();
        drain("interleave");
    endtask

    task automatic test_bad_channel();
        int seen;
        send(3'd5, 16'h3C00, 1'b1);
        send(3'd4, 16'h3C00, 1'b1);
        send(3'd7, 16'h4000, 1'b0);
        idle();
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL bad_channel_out: %0d results for dropped tags, required 0", seen);
        end
        send(3'd1, 16'h3C00, 1'b0); expect_out(3'd1, 16'hC200, 1'b0);
        send(3'd0, 16'h3C00, 1'b0); expect_out(3'd0, 16'h4500, 1'b0);
        idle();
        drain("bad_channel");
    endtask

    task automatic test_saturate();
        send(3'd2, 16'h5A40, 1'b1); expect_out(3'd2, 16'h5A40, 1'b0);
        send(3'd2, 16'h5A40, 1'b0); expect_out(3'd2, 16'h5BFF, 1'b1);
        send(3'd2, 16'h3C00, 1'b0); expect_out(3'd2, 16'h5BFF, 1'b1);
        send(3'd2, 16'h3C00, 1'b1); expect_out(3'd2, 16'h3C00, 1'b0);
        idle();
        drain("saturate");
    endtask

    task automatic test_clear();
        send(3'd3, 16'h4000, 1'b1); expect_out(3'd3, 16'h4000, 1'b0);
        send(3'd3, 16'h4000, 1'b0);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.clear_all = 1'b1;
        idle();
        drain("clear");
        send(3'd3, 16'h3C00, 1'b0); expect_out(3'd3, 16'h3C00, 1'b0);
        send(3'd0, 16'h3C00, 1'b0); expect_out(3'd0, 16'h3C00, 1'b0);
        idle();
        drain("after_clear");
    endtask

    task automatic test_async_reset();
        int seen;
        send(3'd1, 16'h3C00, 1'b1); expect_out(3'd1, 16'h3C00, 1'b0);
        send(3'd1, 16'h3C00, 1'b0);
        send(3'd1, 16'h3C00, 1'b0);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b required 0", bus.out_valid); end
        checks++;
        if (bus.r !== 16'h0000) begin errors++; $display("FAIL async_r: got %h required 0000", bus.r); end
        checks++;
        if (bus.out_ch !== 3'd0) begin errors++; $display("FAIL async_ch: got %0d required 0", bus.out_ch); end
        checks++;
        if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL async_ovf: got %b required 0", bus.out_ovf); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL async_lost: %0d results after release, required 0", seen);
        end
        sb.delete();
        send(3'd0, 16'h3C00, 1'b0); expect_out(3'd0, 16'h3C00, 1'b0);
        idle();
        drain("after_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sequence();
        test_interleave();
        test_bad_channel();
        test_saturate();
        test_clear();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/accu_half_mc.md
# accu_half_mc

Multi-channel, parametrised successor to the single-channel half-precision accumulator. It accepts IEEE-754 binary16 samples tagged with a channel index and converts each to signed fixed point. It accumulates per channel with saturation and a sticky overflow flag, then returns the running sum as binary16. It sits between time-multiplexed MAC lanes and the result write-back, so that one instance serves `CHANNELS` independent dot-product streams.

## Interface
- `FIXEDSIZE`, 20: accumulator width in bits, two's complement.
- `RADIXPOINT`, 11: number of fractional bits of the fixed-point format.
- `CHANNELS`, 4: number of independent accumulators; must be ≥ 1.
- `CH_W`, `$clog2(CHANNELS)` with a minimum of 1: width of the channel index.
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: sample present this cycle.
- `in_first`, in, 1: the sample restarts its channel (acc = sample). Ignored when `in_valid` = 0.
- `in_ch`, in, `CH_W`: channel tag. Values ≥ `CHANNELS` are dropped, with no output.
- `x`, in, 16: binary16 sample.
- `clear_all`, in, 1: synchronous clear of every accumulator and every flag.
- `out_valid`, out, 1: result valid.
- `out_ch`, out, `CH_W`: channel of the result.
- `r`, out, 16: binary16 running sum of `out_ch`.
- `out_ovf`, out, 1: sticky overflow flag of `out_ch`.

## Operation
- Stage 1 (S1): `x` passes through `Float2Fixed` (`FIXEDSIZE`, 16, 10, 5; `RADIXPOINT`). S1 registers the converted value together with valid, first, ch and the conversion-overflow bit.
- Stage 2 (S2), when the S1 entry is valid:
  - If first is set, `acc[ch]` ← value and `ovf[ch]` ← the conversion-overflow bit.
  - Otherwise the sum `acc[ch]` + value is formed at `FIXEDSIZE`+1 bits.
  - A sum above the positive limit (2^(FIXEDSIZE-1) − 1) clamps to that limit. A sum below the negative limit (−2^(FIXEDSIZE-1)) clamps to that limit.
  - `ovf[ch]` ← `ovf[ch]` OR clamp OR the conversion-overflow bit.
- S2 also registers valid and ch into a tag register.
- Stage 3 (S3): `Fixed2Float` converts the accumulator selected by the S2 tag. S3 registers `r`, `out_ch`, `out_ovf` and `out_valid`.
- Only channel `ch` changes per update. The other accumulators hold.
- `clear_all`:
  - Sets every `acc` and every `ovf` to 0 at the edge.
  - Discards the entry in S2 at that edge: no update, and its S2 valid becomes 0.
  - Leaves entries in S1 unaffected; they proceed normally on later edges.
- `out_valid` = 0 means `r`, `out_ch` and `out_ovf` hold their previous values.

## Timing
- Reset (asynchronous, `resetn` low): all accumulators, all flags, all pipeline registers, `r`, `out_ch`, `out_ovf` and `out_valid` are 0. This takes effect immediately, with no clock edge needed.
- Reset mid-stream loses all in-flight samples. The first sample after reset needs `in_first` only for readability, because the accumulators are already 0.
- Latency: a sample accepted at edge k updates its accumulator at edge k+1, and the result appears at edge k+2.
  - `out_valid` is high for the cycle after edge k+2, so `x` to `r` is 3 register stages.
- Throughput: one sample per cycle, with no stall and no backpressure.
- Back-to-back samples on the same channel are correct. The S2 read-modify-write completes in one cycle, so no forwarding is required.
- Simultaneous `clear_all` and a valid sample in S2: clear wins and the sample is lost.

## Structure
- Package `accu_half_pkg` holds:
  - the binary16 field constants (10 mantissa bits, 5 exponent bits);
  - the `fp16_t` typedef;
  - the default `FIXEDSIZE` / `RADIXPOINT`;
  - a function `sat_add(a, b)` that returns the clamped sum and the clamp bit.
- The accumulator array is either a register array or a `CHANNELS`-wide generate loop. There is no RAM, so combinational read is allowed.
- Reused sub-modules: `Float2Fixed` at the input and `Fixed2Float` at the output.
- A sub-module `accu_half_lane` is natural: one accumulator, one sticky flag, `sat_add` and the write-enable logic, instantiated `CHANNELS` times.

## Test plan
- Reset, then ch0 fed 0x3C00 (first), 0x4000, 0x3800 on consecutive cycles -> `out_valid` pulses on 3 consecutive cycles starting 2 edges after the first accept. `r` = 0x3C00, then 0x4200, then 0x4300 (1.0, 3.0, 3.5); `out_ovf` = 0.
- Interleave ch0 at 0x3C00 and ch1 at 0xBC00 for 4 cycles each, with first set on each channel's first sample -> final ch0 `r` = 0x4400 (4.0) and final ch1 `r` = 0xC400 (−4.0); `out_ch` matches each input tag.
- ch2 fed 0x5A40 (200.0) first, then 0x5A40 -> second result = `Fixed2Float(0x7FFFF)` with `out_ovf` = 1. A following 0x3C00 (not first) keeps `out_ovf` = 1. A following 0x3C00 with first set gives `r` = 0x3C00 and `out_ovf` = 0.
- Two samples on ch3 (0x4000, first; then 0x4000), with `clear_all` asserted on the edge where the second is in S2 -> only the first result is output (`r` = 0x4000). A subsequent non-first 0x3C00 on ch3 gives `r` = 0x3C00.
- `in_ch` = 5 with `CHANNELS` = 4 (`CH_W` = 3), `in_valid` = 1 -> no `out_valid`, and no accumulator changes.
- Assert `resetn` low asynchronously while 3 samples are in flight -> all outputs are 0 immediately, and no `out_valid` appears after release.
